// File: rtl/miner_nonce_dispatcher.sv
// miner_nonce_dispatcher
//   Job-side initiator for the miner core. Latches a job (header, target,
//   inclusive nonce range), launches one hash per nonce, walks the range
//   upward modulo 2^NONCE_W and returns a single result record over a
//   valid/ready handshake. A per-nonce watchdog and an abort input end a job
//   early.
//
//   Ports
//     clk, n_rst            clock, synchronous active-low reset
//     job_*                 job offer (valid/ready) with header/target/range
//     abort                 cancel the running job (LAUNCH/WAIT only)
//     core_*                interface to the hash core
//     res_*, timeout_err    result record, held until res_ready
//     busy                  high whenever not IDLE
//     hash_count            only with MINER_DISPATCH_STATS_EN: saturating
//                           count of completed core hashes since reset
//
//   Optional feature macro: MINER_DISPATCH_STATS_EN
//
//   state  | meaning
//   IDLE   | waiting for a job, job_ready=1
//   LAUNCH | one-cycle core_hash_enable pulse for core_nonce
//   WAIT   | waiting for core_finished, watchdog running
//   REPORT | result presented, waiting for res_ready
module miner_nonce_dispatcher #(
  parameter int NONCE_W     = 32,
  parameter int HASH_W      = 256,
  parameter int BLOCK_W     = 608,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [BLOCK_W-1:0] job_block,
  input  logic [HASH_W-1:0]  job_target,
  input  logic [NONCE_W-1:0] job_nonce_start,
  input  logic [NONCE_W-1:0] job_nonce_end,
  input  logic               abort,
  output logic [BLOCK_W-1:0] core_block,
  output logic [NONCE_W-1:0] core_nonce,
  output logic [HASH_W-1:0]  core_target,
  output logic               core_hash_enable,
  input  logic               core_finished,
  input  logic               core_correct,
  input  logic [HASH_W-1:0]  core_hashed,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_found,
  output logic [NONCE_W-1:0] res_nonce,
  output logic [HASH_W-1:0]  res_hash,
  output logic               timeout_err,
  output logic               busy
`ifdef MINER_DISPATCH_STATS_EN
  ,
  output logic [31:0]        hash_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_REPORT
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_t             state;
  state_t             state_next;
  logic [NONCE_W-1:0] nonce_end;
  logic [7:0]         wd_cnt;

  logic job_take;
  logic fin_seen;
  logic ev_found;
  logic ev_last;
  logic ev_step;
  logic ev_timeout;
  logic ev_report;

  always_comb begin
    state_next = state;
    job_take   = 1'b0;
    fin_seen   = 1'b0;
    ev_found   = 1'b0;
    ev_last    = 1'b0;
    ev_step    = 1'b0;
    ev_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (job_valid) begin
          job_take   = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_next = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        // A done left over from the previous nonce may still be high in the
        // first WAIT cycle, so finished only counts once wd_cnt has moved.
        fin_seen = core_finished && (wd_cnt != 8'd0);
        if (abort) begin
          state_next = S_IDLE;
        end else if (fin_seen) begin
          if (core_correct) begin
            ev_found   = 1'b1;
            state_next = S_REPORT;
          end else if (core_nonce == nonce_end) begin
            ev_last    = 1'b1;
            state_next = S_REPORT;
          end else begin
            ev_step    = 1'b1;
            state_next = S_LAUNCH;
          end
        end else if (wd_cnt == TIMEOUT_LIM) begin
          ev_timeout = 1'b1;
          state_next = S_REPORT;
        end
      end
      S_REPORT: begin
        if (res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    ev_report = ev_found | ev_last | ev_timeout;
  end

  assign job_ready        = (state == S_IDLE);
  assign busy             = (state != S_IDLE);
  assign core_hash_enable = (state == S_LAUNCH) && !abort;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      nonce_end   <= '0;
      wd_cnt      <= '0;
      core_block  <= '0;
      core_nonce  <= '0;
      core_target <= '0;
      res_valid   <= 1'b0;
      res_found   <= 1'b0;
      res_nonce   <= '0;
      res_hash    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_next;
      res_valid <= (state_next == S_REPORT);

      if (job_take) begin
        core_block  <= job_block;
        core_target <= job_target;
        core_nonce  <= job_nonce_start;
        nonce_end   <= job_nonce_end;
      end

      if (state == S_LAUNCH) begin
        wd_cnt <= 8'd0;
      end else if (state == S_WAIT) begin
        wd_cnt <= wd_cnt + 8'd1;
      end

      if (ev_step) begin
        core_nonce <= core_nonce + NONCE_W'(1);
      end

      if (ev_report) begin
        res_found   <= ev_found;
        res_nonce   <= core_nonce;
        res_hash    <= ev_timeout ? '0 : core_hashed;
        timeout_err <= ev_timeout;
      end else if ((state == S_REPORT) && res_ready) begin
        timeout_err <= 1'b0;
      end
    end
  end

`ifdef MINER_DISPATCH_STATS_EN
  // An aborted cycle does not count its finished, matching the FSM's view.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hash_count <= '0;
    end else if (fin_seen && !abort && (hash_count != 32'hFFFF_FFFF)) begin
      hash_count <= hash_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_miner_nonce_dispatcher.sv
module tb_miner_nonce_dispatcher;

  localparam int TO_CYC = 255;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         job_valid;
  logic         job_ready;
  logic [607:0] job_block;
  logic [255:0] job_target;
  logic [31:0]  job_nonce_start;
  logic [31:0]  job_nonce_end;
  logic         abort;
  logic [607:0] core_block;
  logic [31:0]  core_nonce;
  logic [255:0] core_target;
  logic         core_hash_enable;
  logic         core_finished;
  logic         core_correct;
  logic [255:0] core_hashed;
  logic         res_valid;
  logic         res_ready;
  logic         res_found;
  logic [31:0]  res_nonce;
  logic [255:0] res_hash;
  logic         timeout_err;
  logic         busy;
`ifdef MINER_DISPATCH_STATS_EN
  logic [31:0]  hash_count;
`endif

  miner_nonce_dispatcher #(
    .NONCE_W(32), .HASH_W(256), .BLOCK_W(608), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_block(job_block), .job_target(job_target),
    .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
    .abort(abort),
    .core_block(core_block), .core_nonce(core_nonce), .core_target(core_target),
    .core_hash_enable(core_hash_enable), .core_finished(core_finished),
    .core_correct(core_correct), .core_hashed(core_hashed),
    .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
    .res_nonce(res_nonce), .res_hash(res_hash), .timeout_err(timeout_err),
    .busy(busy)
`ifdef MINER_DISPATCH_STATS_EN
    , .hash_count(hash_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // core model configuration
  bit          win_en;
  logic [31:0] win_nonce;
  int          core_lat;
  bit          core_never;
  int          core_cnt = 0;

  // monitor state
  logic [31:0]  seen_q[$];
  logic [607:0] cur_block;
  logic [255:0] cur_target;
  int           blk_bad = 0;
  int           cyc = 0;
  int           last_en = 0;
  int           rise_lat = 0;
  bit           rv_d = 1'b0;
  bit           rv_seen = 1'b0;

  function automatic logic [255:0] hash_of(input logic [31:0] n);
    logic [31:0] w;
    w = (n * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    return {8{w}};
  endfunction

  // Behavioural hash core: finishes core_lat cycles after the enable pulse.
  always @(negedge clk) begin
    core_finished = 1'b0;
    core_correct  = 1'b0;
    core_hashed   = '0;
    if (core_hash_enable) begin
      core_cnt = core_never ? 0 : core_lat;
    end else if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        core_finished = 1'b1;
        core_correct  = win_en && (core_nonce == win_nonce);
        core_hashed   = hash_of(core_nonce);
      end
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (core_hash_enable) begin
      last_en = cyc;
      seen_q.push_back(core_nonce);
      if (core_block !== cur_block || core_target !== cur_target) blk_bad++;
    end
    if (res_valid && !rv_d) rise_lat = cyc - last_en;
    if (res_valid) rv_seen = 1'b1;
    rv_d = res_valid;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the range upward mod 2^32, stop at the winner or the end.
  function automatic int walk(input logic [31:0] s, input logic [31:0] e,
                              input bit wen, input logic [31:0] wn,
                              output bit found, output logic [31:0] last);
    logic [31:0] n;
    n = s;
    found = 1'b0;
    last = e;
    for (int k = 1; k < 100; k++) begin
      if (wen && n == wn) begin found = 1'b1; last = n; return k; end
      if (n == e) begin last = e; return k; end
      n = n + 32'd1;
    end
    return 0;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where
  // res_valid is first seen (or after the cycle budget).
  task automatic run_job(input logic [31:0] s, input logic [31:0] e, input bit wen,
                         input logic [31:0] wn, input int lat, input bit never);
    bit got;
    win_en = wen; win_nonce = wn; core_lat = lat; core_never = never;
    seen_q.delete();
    blk_bad = 0;
    cur_block  = {19{$urandom}};
    cur_target = {8{$urandom}};
    job_block = cur_block; job_target = cur_target;
    job_nonce_start = s; job_nonce_end = e;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (res_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    #1;
    chk("res_valid_arrives", got, 1'b1);
  endtask

  task automatic check_job(input logic [31:0] s, input bit efound, input logic [31:0] en,
                           input logic [255:0] eh, input bit eto, input int elat,
                           input int epulses, input int hold);
    int bad;
    chk("res_found", res_found, efound);
    chk("res_nonce", res_nonce, en);
    chk("res_hash", res_hash, eh);
    chk("timeout_err", timeout_err, eto);
    chk("result_latency", rise_lat, elat);
    chk("enable_pulses", seen_q.size(), epulses);
    bad = 0;
    foreach (seen_q[i]) if (seen_q[i] !== s + 32'(i)) bad++;
    chk("nonce_sequence", bad, 0);
    chk("block_target_latched", blk_bad, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_found", res_found, efound);
      chk("hold_nonce", res_nonce, en);
      chk("hold_hash", res_hash, eh);
      chk("hold_timeout", timeout_err, eto);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("release_valid", res_valid, 1'b0);
    chk("release_timeout", timeout_err, 1'b0);
    chk("release_job_ready", job_ready, 1'b1);
  endtask

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
    bit          wen;
    logic [31:0] wn;
    int          lat;
    bit          exp_found;
    logic [31:0] exp_nonce;
    int          exp_pulses;
  } vec_t;

  vec_t vt[5];

  task automatic abort_job(input int lat, input int at_wait);
    win_en = 1'b1; win_nonce = 32'd50; core_lat = lat; core_never = 1'b0;
    seen_q.delete();
    job_nonce_start = 32'd50; job_nonce_end = 32'd60;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    for (int w = 0; w < at_wait; w++) @(negedge clk);
    rv_seen = 1'b0;
    abort = 1'b1;
    #1;
    if (at_wait == 0) chk("abort_launch_no_enable", core_hash_enable, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_job_ready", job_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_res_valid", res_valid, 1'b0);
    repeat (14) @(negedge clk);
    chk("abort_no_result", rv_seen, 1'b0);
  endtask

  initial begin
    bit          f;
    logic [31:0] last;
    int          p;
    logic [31:0] s, e, wn;
    int          len, lat;
    bit          wen;

    vt[0] = '{32'd5, 32'd7, 1'b1, 32'd6, 10, 1'b1, 32'd6, 2};
    vt[1] = '{32'd0, 32'd2, 1'b0, 32'd0, 4, 1'b0, 32'd2, 3};
    vt[2] = '{32'hFFFF_FFFE, 32'd1, 1'b0, 32'd0, 3, 1'b0, 32'd1, 4};
    vt[3] = '{32'd9, 32'd9, 1'b1, 32'd9, 2, 1'b1, 32'd9, 1};
    vt[4] = '{32'd20, 32'd20, 1'b0, 32'd0, 5, 1'b0, 32'd20, 1};

    n_rst = 1'b0; job_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    job_block = '0; job_target = '0; job_nonce_start = '0; job_nonce_end = '0;
    win_en = 1'b0; win_nonce = '0; core_lat = 2; core_never = 1'b0;
    cur_block = '0; cur_target = '0;
    repeat (3) @(negedge clk);
    chk("reset_job_ready", job_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_res_valid", res_valid, 1'b0);
    chk("reset_enable", core_hash_enable, 1'b0);
    chk("reset_core_nonce", core_nonce, 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // directed vectors; first one also holds res_ready low for 5 cycles
    for (int i = 0; i < 5; i++) begin
      run_job(vt[i].s, vt[i].e, vt[i].wen, vt[i].wn, vt[i].lat, 1'b0);
      check_job(vt[i].s, vt[i].exp_found, vt[i].exp_nonce, hash_of(vt[i].exp_nonce),
                1'b0, vt[i].lat + 1, vt[i].exp_pulses, (i == 0) ? 5 : 1);
    end

    // watchdog: core never finishes
    run_job(32'd7, 32'd7, 1'b0, 32'd0, 0, 1'b1);
    check_job(32'd7, 1'b0, 32'd7, '0, 1'b1, TO_CYC + 2, 1, 2);
    // a done in the first WAIT cycle is stale and must not end the nonce
    run_job(32'd100, 32'd200, 1'b1, 32'd100, 1, 1'b0);
    check_job(32'd100, 1'b0, 32'd100, '0, 1'b1, TO_CYC + 2, 1, 0);

    // abort: in WAIT3 without finished, in WAIT3 with finished, in LAUNCH
    abort_job(10, 3);
    abort_job(3, 3);
    abort_job(10, 0);

    // reset in the middle of WAIT
    run_job(32'd3, 32'd3, 1'b1, 32'd3, 2, 1'b0);
    check_job(32'd3, 1'b1, 32'd3, hash_of(32'd3), 1'b0, 3, 1, 0);
    core_lat = 10;
    job_nonce_start = 32'd40; job_nonce_end = 32'd44; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    n_rst = 1'b0;
    @(negedge clk);
    chk("rst_job_ready", job_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_found", res_found, 1'b0);
    chk("rst_res_nonce", res_nonce, 32'd0);
    chk("rst_res_hash", res_hash, '0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_core_nonce", core_nonce, 32'd0);
    chk("rst_core_block", core_block, '0);
    chk("rst_core_target", core_target, '0);
    chk("rst_enable", core_hash_enable, 1'b0);
`ifdef MINER_DISPATCH_STATS_EN
    chk("rst_hash_count", hash_count, 32'd0);
`endif
    rv_seen = 1'b0;
    n_rst = 1'b1;
    repeat (14) @(negedge clk);
    chk("rst_no_result", rv_seen, 1'b0);
`ifdef MINER_DISPATCH_STATS_EN
    run_job(vt[1].s, vt[1].e, vt[1].wen, vt[1].wn, vt[1].lat, 1'b0);
    check_job(vt[1].s, 1'b0, 32'd2, hash_of(32'd2), 1'b0, vt[1].lat + 1, 3, 0);
    chk("stats_hash_count", hash_count, 32'd3);
`endif

    // randomized jobs against the range-walk reference
    for (int r = 0; r < 30; r++) begin
      s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
      len = $urandom_range(1, 5);
      e = s + 32'(len - 1);
      wen = $urandom_range(0, 1);
      wn = s + 32'($urandom_range(0, len - 1));
      lat = $urandom_range(2, 6);
      p = walk(s, e, wen, wn, f, last);
      run_job(s, e, wen, wn, lat, 1'b0);
      check_job(s, f, last, hash_of(last), 1'b0, lat + 1, p, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
